embertrail_dmem_arbiter: RTL and testbench
==========================================

EMBERTRAIL_DMEM_ARBITER -- requirements
Module: embertrail_dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum ACCESS cycles without iMemReady (legal 1..31).
REQ-003 iClock  input  1  rising-edge clock.
REQ-004 iReset_n  input  1  asynchronous active-low reset.
REQ-005 iReq1, iReq2  input  1 each  slot 1 / slot 2 access request (level).
REQ-006 iRW1, iRW2  input  1 each  1 = write, 0 = read.
REQ-007 iAddr1, iAddr2  input  16 each  word address.
REQ-008 iWData1, iWData2  input  16 each  write data.
REQ-009 oAck1, oAck2  output  1 each  one-cycle completion pulse.
REQ-010 oRData1, oRData2  output  16 each  read data, valid with and after the matching ack.
REQ-011 oMemEn, oMemRW, oMemAddr[15:0], oMemWData[15:0]  output  single-port data memory command.
REQ-012 iMemRData  input  16  memory read data; iMemReady  input  1  memory completion.
REQ-013 oBusy  output  1  high whenever the FSM is not in IDLE.
REQ-014 oErr  output  1  one-cycle pulse, coincident with the ack, on timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS and RESPOND.
REQ-016 In IDLE with any iReqN high at a clock edge, the FSM SHALL select one winner, latch its RW, address and write data, clear the wait counter and enter ACCESS.
REQ-017 All memory outputs SHALL be registered: oMemEn=1 and latched fields driven only in ACCESS; oMemEn=0 in IDLE and RESPOND.
REQ-018 In ACCESS with iMemReady=1 at an edge, a read SHALL load iMemRData into the winner's oRDataN, a write SHALL leave oRData unchanged, and the FSM SHALL enter RESPOND.
REQ-019 In ACCESS with iMemReady=0, the counter SHALL increment; when the counter equals TIMEOUT-1 without ready, the FSM SHALL enter RESPOND with oErr set and the winner's oRDataN loaded with 16'h0000 on a read.
REQ-020 RESPOND SHALL last exactly one cycle: winner's oAckN=1 (plus oErr if timed out), then IDLE.
REQ-021 Minimum latency: request sampled in IDLE at edge 0, iMemReady high in cycle 1, oAckN high in cycle 2.
REQ-022 Requesters SHALL hold req and fields stable until ack; a req still high when IDLE is re-entered is a new request.
REQ-023 A request arriving in ACCESS or RESPOND SHALL wait; no request SHALL be dropped while held.
REQ-024 oAck1 and oAck2 SHALL never be high in the same cycle.
REQ-025 With simultaneous requests, the winner SHALL be chosen per REQ-031/REQ-032; the loser SHALL be served in the next IDLE cycle if still requesting.
REQ-026 iMemReady outside ACCESS SHALL be ignored.

Reset
REQ-027 Asserting iReset_n low SHALL immediately force IDLE, and all outputs (oAck*, oErr, oMemEn, oMemRW, oBusy) to 0, oMemAddr, oMemWData and oRData1/2 to 16'h0000, and the counter to 0.
REQ-028 Reset during ACCESS SHALL abandon the access with no ack; the round-robin pointer SHALL reset to "last granted = slot 2".
REQ-029 Operation SHALL resume at the first rising edge after iReset_n deasserts.

Configuration
REQ-030 Macro EMBERTRAIL_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 Defined: on a tie, the slot not granted last SHALL win; the pointer SHALL update in RESPOND; the first tie after reset SHALL go to slot 1.
REQ-032 Undefined: slot 1 SHALL always win ties (program order); no pointer register SHALL exist.

Verification
REQ-033 Slot 1 read addr 16'h0010, memory ready after 1 cycle returning 16'hBEEF -> oMemEn in cycle 1, oAck1 and oRData1=16'hBEEF in cycle 2, oAck2 never set.
REQ-034 Both slots request in the same cycle (slot 1 write 16'h1234 @16'h0020, slot 2 read @16'h0021), ready immediate -> slot 1 served first, then slot 2; round-robin build: next tie goes to slot 2.
REQ-035 Slot 2 read with iMemReady held low, TIMEOUT=16 -> oAck2 and oErr together 17 cycles after the request, oRData2=16'h0000, oBusy low the cycle after.
REQ-036 iReset_n low in the second ACCESS cycle -> oMemEn and oBusy low with no clock edge, no ack; a fresh request after release completes normally.
REQ-037 Fixed-priority build with iReq1 and iReq2 held high continuously -> slot 1 acked every 3 cycles, slot 2 never acked (starvation documented behaviour).

Source files
------------

// File: rtl/embertrail_dmem_arbiter.sv
// Two-slot arbiter in front of a single-port 16-bit data memory.
// Define EMBERTRAIL_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise slot 1 always wins.
module embertrail_dmem_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        iClock,
   input  logic        iReset_n,
   input  logic        iReq1,
   input  logic        iReq2,
   input  logic        iRW1,
   input  logic        iRW2,
   input  logic [15:0] iAddr1,
   input  logic [15:0] iAddr2,
   input  logic [15:0] iWData1,
   input  logic [15:0] iWData2,
   output logic        oAck1,
   output logic        oAck2,
   output logic [15:0] oRData1,
   output logic [15:0] oRData2,
   output logic        oMemEn,
   output logic        oMemRW,
   output logic [15:0] oMemAddr,
   output logic [15:0] oMemWData,
   input  logic [15:0] iMemRData,
   input  logic        iMemReady,
   output logic        oBusy,
   output logic        oErr
);

   localparam int unsigned DataW = 16;
   localparam int unsigned AddrW = 16;
   localparam int unsigned CntW  = 5;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } arbStateT;

   arbStateT             state, stateNext;
   logic                 winSlot2, winSlot2Next;
   logic                 latRW, latRWNext;
   logic [AddrW-1:0]     latAddr, latAddrNext;
   logic [DataW-1:0]     latWData, latWDataNext;
   logic [CntW-1:0]      waitCnt, waitCntNext;

   logic                 ack1Next, ack2Next, errNext;
   logic                 memEnNext, memRWNext, busyNext;
   logic [AddrW-1:0]     memAddrNext;
   logic [DataW-1:0]     memWDataNext;
   logic [DataW-1:0]     rData1Next, rData2Next;
   logic                 grantSlot2;

`ifdef EMBERTRAIL_ARB_ROUND_ROBIN_EN
   logic                 lastSlot2, lastSlot2Next;
`endif

   // Winner selection when leaving IDLE
   always_comb begin
`ifdef EMBERTRAIL_ARB_ROUND_ROBIN_EN
      grantSlot2 = iReq2 & (~iReq1 | ~lastSlot2);
`else
      grantSlot2 = iReq2 & ~iReq1;
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      stateNext    = state;
      winSlot2Next = winSlot2;
      latRWNext    = latRW;
      latAddrNext  = latAddr;
      latWDataNext = latWData;
      waitCntNext  = waitCnt;
      ack1Next     = 1'b0;
      ack2Next     = 1'b0;
      errNext      = 1'b0;
      rData1Next   = oRData1;
      rData2Next   = oRData2;
`ifdef EMBERTRAIL_ARB_ROUND_ROBIN_EN
      lastSlot2Next = lastSlot2;
`endif

      case (state)
         IDLE: begin
            if (iReq1 | iReq2) begin
               winSlot2Next = grantSlot2;
               latRWNext    = grantSlot2 ? iRW2    : iRW1;
               latAddrNext  = grantSlot2 ? iAddr2  : iAddr1;
               latWDataNext = grantSlot2 ? iWData2 : iWData1;
               waitCntNext  = '0;
               stateNext    = ACCESS;
            end
         end

         ACCESS: begin
            if (iMemReady) begin
               if (!latRW) begin
                  if (winSlot2) rData2Next = iMemRData;
                  else          rData1Next = iMemRData;
               end
               ack1Next  = ~winSlot2;
               ack2Next  = winSlot2;
               stateNext = RESPOND;
            end else if (waitCnt == CntLast) begin
               // Timed-out reads return zero so stale data is never mistaken for a result
               if (!latRW) begin
                  if (winSlot2) rData2Next = '0;
                  else          rData1Next = '0;
               end
               ack1Next  = ~winSlot2;
               ack2Next  = winSlot2;
               errNext   = 1'b1;
               stateNext = RESPOND;
            end else begin
               waitCntNext = waitCnt + CntW'(1);
            end
         end

         RESPOND: begin
`ifdef EMBERTRAIL_ARB_ROUND_ROBIN_EN
            lastSlot2Next = winSlot2;
`endif
            stateNext = IDLE;
         end

         default: stateNext = IDLE;
      endcase

      memEnNext    = (stateNext == ACCESS);
      memRWNext    = memEnNext & latRWNext;
      memAddrNext  = memEnNext ? latAddrNext  : '0;
      memWDataNext = memEnNext ? latWDataNext : '0;
      busyNext     = (stateNext != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state     <= IDLE;
         winSlot2  <= 1'b0;
         latRW     <= 1'b0;
         latAddr   <= '0;
         latWData  <= '0;
         waitCnt   <= '0;
         oAck1     <= 1'b0;
         oAck2     <= 1'b0;
         oErr      <= 1'b0;
         oRData1   <= '0;
         oRData2   <= '0;
         oMemEn    <= 1'b0;
         oMemRW    <= 1'b0;
         oMemAddr  <= '0;
         oMemWData <= '0;
         oBusy     <= 1'b0;
      end else begin
         state     <= stateNext;
         winSlot2  <= winSlot2Next;
         latRW     <= latRWNext;
         latAddr   <= latAddrNext;
         latWData  <= latWDataNext;
         waitCnt   <= waitCntNext;
         oAck1     <= ack1Next;
         oAck2     <= ack2Next;
         oErr      <= errNext;
         oRData1   <= rData1Next;
         oRData2   <= rData2Next;
         oMemEn    <= memEnNext;
         oMemRW    <= memRWNext;
         oMemAddr  <= memAddrNext;
         oMemWData <= memWDataNext;
         oBusy     <= busyNext;
      end
   end

`ifdef EMBERTRAIL_ARB_ROUND_ROBIN_EN
   // Reset as if slot 2 was granted last so the first tie goes to slot 1
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) lastSlot2 <= 1'b1;
      else           lastSlot2 <= lastSlot2Next;
   end
`endif

endmodule

// File: tb/tb_embertrail_dmem_arbiter.sv
// Directed bench for embertrail_dmem_arbiter: per-cycle vector table plus timeout, reset and starvation sequences.
module tb_embertrail_dmem_arbiter;

`ifdef EMBERTRAIL_ARB_ROUND_ROBIN_EN
   localparam bit Rr = 1'b1;
`else
   localparam bit Rr = 1'b0;
`endif

   logic        iClock = 1'b0;
   logic        iReset_n;
   logic        iReq1, iReq2, iRW1, iRW2;
   logic [15:0] iAddr1, iAddr2, iWData1, iWData2;
   logic        oAck1, oAck2, oMemEn, oMemRW, oBusy, oErr;
   logic [15:0] oRData1, oRData2, oMemAddr, oMemWData;
   logic [15:0] iMemRData;
   logic        iMemReady;

   int checks = 0;
   int errors = 0;

   embertrail_dmem_arbiter #(.TIMEOUT(16)) dut (
      .iClock(iClock), .iReset_n(iReset_n),
      .iReq1(iReq1), .iReq2(iReq2), .iRW1(iRW1), .iRW2(iRW2),
      .iAddr1(iAddr1), .iAddr2(iAddr2), .iWData1(iWData1), .iWData2(iWData2),
      .oAck1(oAck1), .oAck2(oAck2), .oRData1(oRData1), .oRData2(oRData2),
      .oMemEn(oMemEn), .oMemRW(oMemRW), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
      .iMemRData(iMemRData), .iMemReady(iMemReady), .oBusy(oBusy), .oErr(oErr)
   );

   always #5 iClock = ~iClock;

   typedef struct {
      string       name;
      logic        r1, r2, w1, w2;
      logic [15:0] a1, a2, d1, d2;
      logic        rdy;
      logic [15:0] mrd;
      logic [69:0] exp;
   } vecT;

   vecT vecs[$];

   function automatic vecT mk(string nm, logic r1, logic r2, logic w1, logic w2,
                              logic [15:0] a1, logic [15:0] a2, logic [15:0] d1, logic [15:0] d2,
                              logic rdy, logic [15:0] mrd,
                              logic k1, logic k2, logic er, logic en, logic rw, logic bs,
                              logic [15:0] ma, logic [15:0] mw, logic [15:0] rd1, logic [15:0] rd2);
      vecT v;
      v.name = nm; v.r1 = r1; v.r2 = r2; v.w1 = w1; v.w2 = w2;
      v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2; v.rdy = rdy; v.mrd = mrd;
      v.exp = {k1, k2, er, en, rw, bs, ma, mw, rd1, rd2};
      return v;
   endfunction

   function automatic logic [69:0] observed();
      return {oAck1, oAck2, oErr, oMemEn, oMemRW, oBusy, oMemAddr, oMemWData, oRData1, oRData2};
   endfunction

   task automatic check(input string nm, input logic [69:0] got, input logic [69:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   task automatic idleInputs();
      iReq1 = 0; iReq2 = 0; iRW1 = 0; iRW2 = 0;
      iAddr1 = '0; iAddr2 = '0; iWData1 = '0; iWData2 = '0;
      iMemReady = 0; iMemRData = '0;
   endtask

   // Single slot read with an immediately ready memory; ack expected two edges after the request
   task automatic runRead(input bit s2, input logic [15:0] addr, input logic [15:0] mrd, input string nm);
      int n;
      @(negedge iClock);
      iReq1 = ~s2; iReq2 = s2; iRW1 = 0; iRW2 = 0;
      iAddr1 = addr; iAddr2 = addr; iMemReady = 1; iMemRData = mrd;
      n = 0;
      do begin
         @(posedge iClock); #1; n++;
      end while (!(oAck1 | oAck2) && n < 10);
      check({nm, "_lat"}, 70'(n), 70'(2));
      check({nm, "_ack"}, {68'(s2 ? oRData2 : oRData1), oAck1, oAck2}, {68'(mrd), ~s2, s2});
      @(negedge iClock);
      idleInputs();
      @(posedge iClock); #1;
   endtask

   initial begin
      logic [15:0] rrd2;
      int n, c1, c2, ov;

      rrd2 = Rr ? 16'hCAFE : 16'h0000;
      vecs.push_back(mk("tie1_acc", 1,1,1,0, 16'h0020,16'h0021,16'h1234,0, 0,0,      0,0,0,1,1,1, 16'h0020,16'h1234,0,0));
      vecs.push_back(mk("tie1_ack", 1,1,1,0, 16'h0020,16'h0021,16'h1234,0, 1,16'h5555, 1,0,0,0,0,1, 0,0,0,0));
      vecs.push_back(mk("tie1_idle",1,1,1,0, 16'h0020,16'h0021,16'h1234,0, 1,16'h5555, 0,0,0,0,0,0, 0,0,0,0));
      vecs.push_back(mk("tie2_acc", 1,1,1,0, 16'h0020,16'h0021,16'h1234,0, 0,0,
                        0,0,0,1,~Rr,1, Rr ? 16'h0021 : 16'h0020, Rr ? 16'h0000 : 16'h1234, 0,0));
      vecs.push_back(mk("tie2_ack", 1,1,1,0, 16'h0020,16'h0021,16'h1234,0, 1,16'hCAFE,
                        ~Rr,Rr,0,0,0,1, 0,0,0,rrd2));
      vecs.push_back(mk("s2_wait",  0,1,1,0, 16'h0020,16'h0021,16'h1234,0, 0,0,      0,0,0,0,0,0, 0,0,0,rrd2));
      vecs.push_back(mk("s2_acc",   0,1,1,0, 16'h0020,16'h0021,16'h1234,0, 0,0,      0,0,0,1,0,1, 16'h0021,0,0,rrd2));
      vecs.push_back(mk("s2_ack",   0,1,1,0, 16'h0020,16'h0021,16'h1234,0, 1,16'h0BAD, 0,1,0,0,0,1, 0,0,0,16'h0BAD));
      vecs.push_back(mk("s2_idle",  0,0,0,0, 0,0,0,0, 0,0,                            0,0,0,0,0,0, 0,0,0,16'h0BAD));
      vecs.push_back(mk("rd1_acc",  1,0,0,0, 16'h0010,0,0,0, 0,0,                     0,0,0,1,0,1, 16'h0010,0,0,16'h0BAD));
      vecs.push_back(mk("rd1_ack",  1,0,0,0, 16'h0010,0,0,0, 1,16'hBEEF,              1,0,0,0,0,1, 0,0,16'hBEEF,16'h0BAD));
      vecs.push_back(mk("rd1_idle", 0,0,0,0, 0,0,0,0, 0,0,                            0,0,0,0,0,0, 0,0,16'hBEEF,16'h0BAD));
      vecs.push_back(mk("wr2_acc",  0,1,0,1, 0,16'h0040,0,16'h7777, 0,0,              0,0,0,1,1,1, 16'h0040,16'h7777,16'hBEEF,16'h0BAD));
      vecs.push_back(mk("wr2_wait", 0,1,0,1, 0,16'h0040,0,16'h7777, 0,0,              0,0,0,1,1,1, 16'h0040,16'h7777,16'hBEEF,16'h0BAD));
      vecs.push_back(mk("wr2_ack",  0,1,0,1, 0,16'h0040,0,16'h7777, 1,16'h1111,       0,1,0,0,0,1, 0,0,16'hBEEF,16'h0BAD));
      vecs.push_back(mk("wr2_idle", 0,0,0,0, 0,0,0,0, 0,0,                            0,0,0,0,0,0, 0,0,16'hBEEF,16'h0BAD));

      idleInputs();
      iReset_n = 0;
      @(posedge iClock); @(posedge iClock); #1;
      check("reset_state", observed(), 70'd0);
      @(negedge iClock);
      iReset_n = 1;

      // Cycle-by-cycle vector table
      foreach (vecs[i]) begin
         @(negedge iClock);
         iReq1 = vecs[i].r1; iReq2 = vecs[i].r2; iRW1 = vecs[i].w1; iRW2 = vecs[i].w2;
         iAddr1 = vecs[i].a1; iAddr2 = vecs[i].a2; iWData1 = vecs[i].d1; iWData2 = vecs[i].d2;
         iMemReady = vecs[i].rdy; iMemRData = vecs[i].mrd;
         @(posedge iClock); #1;
         check(vecs[i].name, observed(), vecs[i].exp);
      end

      // Slot 2 read with memory never ready
      @(negedge iClock);
      idleInputs();
      iReq2 = 1; iAddr2 = 16'h0050;
      @(posedge iClock); #1;
      n = 0;
      while (!(oAck1 | oAck2) && n < 40) begin
         @(posedge iClock); #1; n++;
      end
      check("tmo_latency", 70'(n + 1), 70'(17));
      check("tmo_ack_err", {67'(oRData2), oAck1, oAck2, oErr}, {67'h0, 1'b0, 1'b1, 1'b1});
      iReq2 = 0;
      @(posedge iClock); #1;
      check("tmo_after", {68'h0, oBusy, oErr}, 70'd0);

      runRead(1'b0, 16'h0065, 16'h2468, "pre_rst");

      // Reset asserted in the second ACCESS cycle
      @(negedge iClock);
      iReq1 = 1; iAddr1 = 16'h0060; iMemReady = 0;
      @(posedge iClock); #1;
      check("rst_acc1", {54'h0, oMemAddr, oMemEn, oBusy}, {54'h0, 16'h0060, 1'b1, 1'b1});
      @(posedge iClock); #3;
      iReset_n = 0;
      #1;
      check("rst_async", observed(), 70'd0);
      iReq1 = 0;
      @(posedge iClock); #1;
      check("rst_held", {67'h0, oAck1, oAck2, oBusy}, 70'd0);
      @(negedge iClock);
      iReset_n = 1;

      // Tie right after reset goes to slot 1 in either build
      @(negedge iClock);
      iReq1 = 1; iReq2 = 1; iAddr1 = 16'h0070; iAddr2 = 16'h0071; iMemReady = 1; iMemRData = 16'h1357;
      @(posedge iClock); #1;
      check("post_rst_acc", {54'h0, oMemAddr, oMemEn, oBusy}, {54'h0, 16'h0070, 1'b1, 1'b1});
      @(posedge iClock); #1;
      check("post_rst_ack", {52'h0, oRData1, oAck1, oAck2}, {52'h0, 16'h1357, 1'b1, 1'b0});
      @(negedge iClock);
      idleInputs();
      @(posedge iClock); @(posedge iClock); #1;

      // Both slots held with an always-ready memory
      @(negedge iClock);
      iReq1 = 1; iReq2 = 1; iAddr1 = 16'h0080; iAddr2 = 16'h0081; iMemReady = 1; iMemRData = 16'h4242;
      c1 = 0; c2 = 0; ov = 0;
      for (int e = 0; e < 30; e++) begin
         @(posedge iClock); #1;
         if (oAck1) c1++;
         if (oAck2) c2++;
         if (oAck1 && oAck2) ov++;
      end
      check("hold_ack1", 70'(c1), Rr ? 70'(5) : 70'(10));
      check("hold_ack2", 70'(c2), Rr ? 70'(5) : 70'(0));
      check("hold_overlap", 70'(ov), 70'(0));
      @(negedge iClock);
      idleInputs();
      @(posedge iClock); @(posedge iClock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
